// File: rtl/key_load_ctrl.sv
// key_load_ctrl: key-delivery controller for logic-locked FSMs.
// Fetches KEY_W key bits MSB-first from the secure key store over a four-phase
// req/ack handshake, shifts them into the key register, and holds the locked
// FSM in reset until the whole key is present.
//
// Ports:
//   clk, rst   - clock (posedge), asynchronous active-low reset
//   start      - level, begin a load (honoured in IDLE and ERR only)
//   relock     - level, wipe key and return to IDLE (beats start and ack)
//   nvm_req    - registered request to the key store
//   nvm_ack    - key store acknowledge, nvm_bit valid while high
//   nvm_bit    - serial key bit
//   key_out    - key to the locked FSM's keyinput pins
//   key_valid  - key fully loaded, FSM released
//   fsm_rst    - active-high reset to the locked FSM
//   busy       - handshake in progress
//   err        - sticky error (handshake timeout or parity)
//
// Optional: define KEY_LOAD_PARITY_EN to fetch one extra even-parity bit after
// the key bits; a mismatch lands in ERR instead of RUN.
module key_load_ctrl #(
  parameter int KEY_W   = 8,
  parameter int TMO_CYC = 255,
  parameter int TMO_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             relock,
  output logic             nvm_req,
  input  logic             nvm_ack,
  input  logic             nvm_bit,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             fsm_rst,
  output logic             busy,
  output logic             err
);

`ifdef KEY_LOAD_PARITY_EN
  localparam int NBITS = KEY_W + 1;
`else
  localparam int NBITS = KEY_W;
`endif
  localparam int CNT_W = $clog2(NBITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACKLO, S_RUN, S_ERR} state_e;

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d, tmo_inc;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic               frst_q, frst_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               tmo_hit;
  logic               load_ok;

  assign tmo_inc = tmo_q + 1'b1;
  assign tmo_hit = (tmo_inc == TMO_W'(TMO_CYC));

`ifdef KEY_LOAD_PARITY_EN
  logic par_q, par_d;
  // even parity over key bits plus the trailing parity bit
  assign load_ok = ~((^key_q) ^ par_q);
`else
  assign load_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    req_d     = req_q;
    valid_d   = valid_q;
    frst_d    = frst_q;
    busy_d    = busy_q;
    err_d     = err_q;
`ifdef KEY_LOAD_PARITY_EN
    par_d     = par_q;
`endif
    if (relock) begin
      state_d   = S_IDLE;
      key_d     = '0;
      bit_cnt_d = '0;
      tmo_d     = '0;
      req_d     = 1'b0;
      valid_d   = 1'b0;
      frst_d    = 1'b1;
      busy_d    = 1'b0;
      err_d     = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_ERR: begin
          if (start) begin
            state_d   = S_REQ;
            key_d     = '0;
            bit_cnt_d = '0;
            tmo_d     = '0;
            req_d     = 1'b1;
            busy_d    = 1'b1;
            err_d     = 1'b0;
          end
        end
        S_REQ: begin
          if (nvm_ack) begin
`ifdef KEY_LOAD_PARITY_EN
            // last fetched bit is parity and stays out of the key register
            if (bit_cnt_q == CNT_W'(KEY_W)) par_d = nvm_bit;
            else key_d = {key_q[KEY_W-2:0], nvm_bit};
`else
            key_d = {key_q[KEY_W-2:0], nvm_bit};
`endif
            bit_cnt_d = bit_cnt_q + 1'b1;
            tmo_d     = '0;
            req_d     = 1'b0;
            state_d   = S_ACKLO;
          end else begin
            tmo_d = tmo_inc;
            if (tmo_hit) begin
              state_d = S_ERR;
              err_d   = 1'b1;
              key_d   = '0;
              req_d   = 1'b0;
              busy_d  = 1'b0;
            end
          end
        end
        S_ACKLO: begin
          if (!nvm_ack) begin
            tmo_d = '0;
            if (bit_cnt_q == CNT_W'(NBITS)) begin
              busy_d = 1'b0;
              if (load_ok) begin
                state_d = S_RUN;
                valid_d = 1'b1;
                frst_d  = 1'b0;
              end else begin
                state_d = S_ERR;
                err_d   = 1'b1;
                key_d   = '0;
              end
            end else begin
              state_d = S_REQ;
              req_d   = 1'b1;
            end
          end else begin
            tmo_d = tmo_inc;
            if (tmo_hit) begin
              state_d = S_ERR;
              err_d   = 1'b1;
              key_d   = '0;
              busy_d  = 1'b0;
            end
          end
        end
        S_RUN: ; // key held, start ignored; only relock leaves
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      key_q     <= '0;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      frst_q    <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef KEY_LOAD_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      frst_q    <= frst_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
`ifdef KEY_LOAD_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign nvm_req   = req_q;
  assign key_out   = key_q;
  assign key_valid = valid_q;
  assign fsm_rst   = frst_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
